// File: rtl/dsamp_frame_buf_if.sv
// ---------------------------------------------------------------------------
// dsamp_frame_buf_if
// Readout stream carrying rescaled frame samples out of dsamp_frame_buf.
//
//   m_data   signed sample being offered
//   m_valid  m_data is valid
//   m_ready  downstream accepts; a transfer happens when m_valid && m_ready
//   m_last   marks the final sample of the frame
//
// master: frame buffer side, slave: consumer side.
// ---------------------------------------------------------------------------
interface dsamp_frame_buf_if #(
   parameter int OUT_WIDTH = 14
);
   logic signed [OUT_WIDTH-1:0] m_data;
   logic                        m_valid;
   logic                        m_ready;
   logic                        m_last;

   modport master (
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/dsamp_frame_buf.sv
// ---------------------------------------------------------------------------
// dsamp_frame_buf
// Capture stage behind the decimator. Each decimated sum is rescaled to
// sample width (round half up, saturate). On arm, one frame of 2^DEPTH_LOG2
// samples is recorded into RAM, then drained over a valid/ready stream.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   arm        one-cycle capture request, honoured only in IDLE
//   dsoutdata  signed decimator sum
//   out_en     dsoutdata valid strobe
//   m_if       readout stream (m_data, m_valid, m_ready, m_last)
//   busy       high in CAPTURE or DRAIN
//   done       one-cycle pulse after the final sample is accepted
//   clip       sticky saturation flag for the current frame
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for arm; input samples dropped
// ST_CAPTURE | writing rescaled samples to RAM at wr_ptr
// ST_DRAIN | reading RAM and streaming the frame out
// ---------------------------------------------------------------------------
module dsamp_frame_buf #(
   parameter int IN_WIDTH   = 18,
   parameter int OUT_WIDTH  = 14,
   parameter int SHIFT      = 4,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic signed [IN_WIDTH-1:0] dsoutdata,
   input  logic                       out_en,
   dsamp_frame_buf_if.master          m_if,
   output logic                       busy,
   output logic                       done,
   output logic                       clip
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic signed [IN_WIDTH:0] RND     = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT-1);
   localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DRAIN
   } state_t;

   state_t state_q, state_d;

   // ------------------------------------------------------------------
   // Rescale: one extra bit of headroom so the rounding add cannot wrap
   // ------------------------------------------------------------------
   logic signed [IN_WIDTH:0]    sum_ext;
   logic signed [IN_WIDTH:0]    round_sum;
   logic signed [IN_WIDTH:0]    scaled;
   logic                        sat_hi;
   logic                        sat_lo;
   logic signed [OUT_WIDTH-1:0] sample_sat;

   always_comb begin
      sum_ext    = {dsoutdata[IN_WIDTH-1], dsoutdata};
      round_sum  = sum_ext + RND;
      scaled     = round_sum >>> SHIFT;
      sat_hi     = (scaled > SAT_MAX);
      sat_lo     = (scaled < SAT_MIN);
      sample_sat = scaled[OUT_WIDTH-1:0];
      if (sat_hi) begin
         sample_sat = SAT_MAX[OUT_WIDTH-1:0];
      end else if (sat_lo) begin
         sample_sat = SAT_MIN[OUT_WIDTH-1:0];
      end
   end

   // ------------------------------------------------------------------
   // Capture side
   // ------------------------------------------------------------------
   logic signed [OUT_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0]       wr_ptr_q;
   logic                        clip_q;
   logic                        arm_acc;
   logic                        cap_wr;
   logic                        cap_end;

   assign arm_acc = (state_q == ST_IDLE) && arm;
   assign cap_wr  = (state_q == ST_CAPTURE) && out_en;
   assign cap_end = cap_wr && (&wr_ptr_q);

   always_ff @(posedge clk) begin
      if (cap_wr) begin
         mem[wr_ptr_q] <= sample_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         clip_q   <= 1'b0;
      end else if (arm_acc) begin
         wr_ptr_q <= '0;
         clip_q   <= 1'b0;
      end else if (cap_wr) begin
         wr_ptr_q <= wr_ptr_q + 1'b1;
         if (sat_hi || sat_lo) begin
            clip_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Drain side: RAM read (1 cycle) -> skid -> output register.
   // At most two samples are in flight or buffered beyond the output
   // register, so a stalled consumer never loses a read already issued.
   // ------------------------------------------------------------------
   logic [DEPTH_LOG2:0]         rd_cnt_q;
   logic signed [OUT_WIDTH-1:0] ram_q;
   logic                        rd_pend_q;
   logic                        rd_pend_last_q;

   logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic                        out_v_q, out_v_d;
   logic                        out_last_q, out_last_d;
   logic signed [OUT_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                        skid_v_q, skid_v_d;
   logic                        skid_last_q, skid_last_d;

   logic       pop;
   logic       last_xfer;
   logic       out_free;
   logic [1:0] occ;
   logic       rd_issue;
   logic       done_q;

   assign pop       = out_v_q && m_if.m_ready;
   assign last_xfer = pop && out_last_q;
   assign out_free  = !out_v_q || pop;

   always_comb begin
      occ = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_pend_q} - {1'b0, pop};
      rd_issue = (state_q == ST_DRAIN)
               && (rd_cnt_q != (DEPTH_LOG2+1)'(DEPTH))
               && (occ < 2'd2);
   end

   always_ff @(posedge clk) begin
      if (rd_issue) begin
         ram_q <= mem[rd_cnt_q[DEPTH_LOG2-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_q       <= '0;
         rd_pend_q      <= 1'b0;
         rd_pend_last_q <= 1'b0;
      end else begin
         rd_pend_q      <= rd_issue;
         rd_pend_last_q <= rd_issue && (rd_cnt_q == (DEPTH_LOG2+1)'(DEPTH-1));
         if (cap_end) begin
            rd_cnt_q <= '0;
         end else if (rd_issue) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
         end
      end
   end

   // Oldest sample always sits in the output register, then skid, then RAM.
   always_comb begin
      out_data_d  = out_data_q;
      out_v_d     = out_v_q;
      out_last_d  = out_last_q;
      skid_data_d = skid_data_q;
      skid_v_d    = skid_v_q;
      skid_last_d = skid_last_q;
      if (out_free) begin
         if (skid_v_q) begin
            out_data_d  = skid_data_q;
            out_v_d     = 1'b1;
            out_last_d  = skid_last_q;
            skid_v_d    = rd_pend_q;
            skid_data_d = ram_q;
            skid_last_d = rd_pend_last_q;
         end else if (rd_pend_q) begin
            out_data_d = ram_q;
            out_v_d    = 1'b1;
            out_last_d = rd_pend_last_q;
         end else begin
            out_v_d    = 1'b0;
            out_last_d = 1'b0;
         end
      end else if (rd_pend_q) begin
         skid_data_d = ram_q;
         skid_v_d    = 1'b1;
         skid_last_d = rd_pend_last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_v_q     <= 1'b0;
         out_last_q  <= 1'b0;
         skid_data_q <= '0;
         skid_v_q    <= 1'b0;
         skid_last_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_v_q     <= out_v_d;
         out_last_q  <= out_last_d;
         skid_data_q <= skid_data_d;
         skid_v_q    <= skid_v_d;
         skid_last_q <= skid_last_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= last_xfer;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (cap_end) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (last_xfer) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign m_if.m_data  = out_data_q;
   assign m_if.m_valid = out_v_q;
   assign m_if.m_last  = out_last_q;
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;
   assign clip         = clip_q;

endmodule

// File: tb/tb_dsamp_frame_buf.sv
// ---------------------------------------------------------------------------
// tb_dsamp_frame_buf
// Directed bench for dsamp_frame_buf with an 8-sample frame.
// ---------------------------------------------------------------------------
module tb_dsamp_frame_buf;

   localparam int IN_WIDTH   = 18;
   localparam int OUT_WIDTH  = 14;
   localparam int SHIFT      = 4;
   localparam int DEPTH_LOG2 = 3;
   localparam int NS         = 8;

   logic                       clk;
   logic                       rst;
   logic                       arm;
   logic signed [IN_WIDTH-1:0] dsoutdata;
   logic                       out_en;
   logic                       busy;
   logic                       done;
   logic                       clip;

   dsamp_frame_buf_if #(.OUT_WIDTH(OUT_WIDTH)) m_if ();

   dsamp_frame_buf #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT),
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .dsoutdata(dsoutdata),
      .out_en   (out_en),
      .m_if     (m_if),
      .busy     (busy),
      .done     (done),
      .clip     (clip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int done_cnt = 0;
   int got [NS];
   int got_last [NS];
   int n_got;
   int first_cyc;
   int last_cyc;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic feed(input int v, input int gap);
      dsoutdata = v[IN_WIDTH-1:0];
      out_en    = 1'b1;
      tick();
      out_en    = 1'b0;
      repeat (gap) tick();
   endtask

   // mode 0: ready always high; mode 1: 1-on/2-off plus a 10-cycle stall;
   // mode 2: ready every other cycle while arm/out_en are poked.
   task automatic collect(input int mode);
      int  cyc;
      int  held_v;
      int  held_d;
      int  held_l;
      int  r;
      n_got     = 0;
      first_cyc = -1;
      last_cyc  = -1;
      cyc       = 0;
      held_v    = 0;
      held_d    = 0;
      held_l    = 0;
      while (n_got < NS && cyc < 300) begin
         if (held_v != 0) begin
            chk("stall_valid", int'(m_if.m_valid), 1);
            chk("stall_data", int'(m_if.m_data), held_d);
            chk("stall_last", int'(m_if.m_last), held_l);
         end
         case (mode)
            0:       r = 1;
            1:       r = (cyc >= 6 && cyc < 16) ? 0 : ((cyc % 3 == 0) ? 1 : 0);
            default: r = (cyc % 2 == 0) ? 1 : 0;
         endcase
         if (mode == 2) begin
            arm       = (cyc == 3);
            out_en    = (cyc < 6);
            dsoutdata = 18'(16 * 55);
         end
         m_if.m_ready = (r != 0);
         if (m_if.m_valid && first_cyc < 0) first_cyc = cyc;
         if (m_if.m_valid && r != 0) begin
            got[n_got]      = int'(m_if.m_data);
            got_last[n_got] = int'(m_if.m_last);
            n_got++;
            last_cyc = cyc;
            held_v   = 0;
         end else if (m_if.m_valid) begin
            held_v = 1;
            held_d = int'(m_if.m_data);
            held_l = int'(m_if.m_last);
         end else begin
            held_v = 0;
         end
         tick();
         cyc++;
      end
      m_if.m_ready = 1'b0;
      arm          = 1'b0;
      out_en       = 1'b0;
      chk("xfer_count", n_got, NS);
      chk("post_valid", int'(m_if.m_valid), 0);
      chk("post_last", int'(m_if.m_last), 0);
      chk("done_pulse", int'(done), 1);
      chk("busy_with_done", int'(busy), 0);
      tick();
      chk("done_width", int'(done), 0);
   endtask

   task automatic check_frame(input string tag, input int exp [NS]);
      for (int i = 0; i < NS; i++) begin
         chk({tag, "_data"}, got[i], exp[i]);
         chk({tag, "_last"}, got_last[i], (i == NS-1) ? 1 : 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp [NS];
      int sums [NS];

      rst          = 1'b1;
      arm          = 1'b0;
      out_en       = 1'b0;
      dsoutdata    = '0;
      m_if.m_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", int'(m_if.m_valid), 0);
      chk("rst_last", int'(m_if.m_last), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_clip", int'(clip), 0);
      chk("rst_data", int'(m_if.m_data), 0);
      rst = 1'b0;
      tick();

      // 1: rounding/saturation, full-rate drain
      sums = '{7, 8, -8, -9, 24, 0, 131071, -131072};
      exp  = '{0, 1, 0, -1, 2, 0, 8191, -8192};
      done_cnt = 0;
      arm_pulse();
      chk("t1_busy", int'(busy), 1);
      for (int i = 0; i < NS; i++) feed(sums[i], 0);
      collect(0);
      check_frame("t1", exp);
      chk("t1_first_valid_le2", (first_cyc >= 0 && first_cyc <= 2) ? 1 : 0, 1);
      chk("t1_burst_span", last_cyc - first_cyc, NS - 1);
      chk("t1_clip", int'(clip), 1);
      tick();
      tick();
      chk("t1_clip_held", int'(clip), 1);
      chk("t1_done_cnt", done_cnt, 1);

      // 2: gapped input, clip cleared by arm
      done_cnt = 0;
      arm_pulse();
      chk("t2_clip_cleared", int'(clip), 0);
      for (int k = 0; k < NS; k++) begin
         feed(16 * k, 4);
         chk("t2_busy", int'(busy), 1);
      end
      collect(0);
      for (int k = 0; k < NS; k++) exp[k] = k;
      check_frame("t2", exp);
      chk("t2_clip", int'(clip), 0);
      chk("t2_done_cnt", done_cnt, 1);

      // 3: backpressure
      done_cnt = 0;
      arm_pulse();
      for (int k = 0; k < NS; k++) feed(16 * (k + 10), 0);
      collect(1);
      for (int k = 0; k < NS; k++) exp[k] = k + 10;
      check_frame("t3", exp);
      chk("t3_done_cnt", done_cnt, 1);

      // 5: ignored requests
      done_cnt = 0;
      for (int i = 0; i < 3; i++) feed(16 * 99, 0);
      chk("t5_idle_valid", int'(m_if.m_valid), 0);
      chk("t5_idle_busy", int'(busy), 0);
      dsoutdata = 18'(16 * 77);
      out_en    = 1'b1;
      arm_pulse();
      out_en    = 1'b0;
      for (int k = 0; k < 4; k++) feed(16 * (k + 20), 0);
      arm_pulse();
      for (int k = 4; k < NS; k++) feed(16 * (k + 20), 1);
      collect(2);
      for (int k = 0; k < NS; k++) exp[k] = k + 20;
      check_frame("t5", exp);
      repeat (4) tick();
      chk("t5_no_restart_busy", int'(busy), 0);
      chk("t5_no_restart_valid", int'(m_if.m_valid), 0);
      chk("t5_done_cnt", done_cnt, 1);

      // 6: reset mid-capture
      done_cnt = 0;
      arm_pulse();
      for (int k = 0; k < 3; k++) feed(16 * (k + 30) + 8 * 16 * 64, 0);
      rst = 1'b1;
      tick();
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_valid", int'(m_if.m_valid), 0);
      chk("t6_rst_last", int'(m_if.m_last), 0);
      chk("t6_rst_clip", int'(clip), 0);
      chk("t6_rst_data", int'(m_if.m_data), 0);
      rst = 1'b0;
      tick();
      chk("t6_rst_done_cnt", done_cnt, 0);
      arm_pulse();
      for (int k = 0; k < NS; k++) feed(16 * (k - 4), 0);
      collect(0);
      for (int k = 0; k < NS; k++) exp[k] = k - 4;
      check_frame("t6", exp);
      chk("t6_done_cnt", done_cnt, 1);
      chk("t6_clip", int'(clip), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
